// File: rtl/cpu_wb_pkg.sv
// Shared types for the writeback merge stage: the buffered side-result entry
// and the merge FSM state encoding.
package cpu_wb_pkg;

  localparam int WB_DATA_WIDTH     = 32;
  localparam int WB_REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [WB_REG_ADDR_WIDTH-1:0] reg_dest;
    logic [WB_DATA_WIDTH-1:0]     data;
  } wb_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/cpu_wb_fifo.sv
// Synchronous FIFO of side writeback entries; pushes into a full FIFO and pops
// from an empty one are ignored.
module cpu_wb_fifo
  import cpu_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                entry,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so wrap at DEPTH is free.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

endmodule

// File: rtl/cpu_writeback_merge.sv
// Merges the in-order pipeline result and NUM_LL buffered side results into one
// register-file write port. Optional counters enabled by CPU_WB_PERF_EN.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   NORMAL | pipe write wins the port; FIFO head drains into idle cycles
//   DRAIN  | one-cycle forced stall; FIFO head writes, pipe slot is held
module cpu_writeback_merge
  import cpu_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
  parameter int NUM_LL         = 2,
  parameter int BUF_DEPTH      = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               pipe_valid,
  input  logic                               pipe_reg_write,
  input  logic                               pipe_mem_to_reg,
  input  logic [DATA_WIDTH-1:0]              pipe_alu_data,
  input  logic [DATA_WIDTH-1:0]              pipe_mem_data,
  input  logic [REG_ADDR_WIDTH-1:0]          pipe_reg_dest,
  input  logic [NUM_LL-1:0]                  side_valid,
  output logic [NUM_LL-1:0]                  side_ready,
  input  logic [NUM_LL*REG_ADDR_WIDTH-1:0]   side_reg_dest,
  input  logic [NUM_LL*DATA_WIDTH-1:0]       side_data,
  output logic                               rf_write_enable,
  output logic [REG_ADDR_WIDTH-1:0]          rf_write_reg,
  output logic [DATA_WIDTH-1:0]              rf_write_data,
  output logic                               stall,
  output logic [$clog2(BUF_DEPTH):0]         buf_count
`ifdef CPU_WB_PERF_EN
  ,
  output logic [31:0]                        perf_stall_cycles,
  output logic [31:0]                        perf_side_writes,
  output logic [31:0]                        perf_full_cycles
`endif
);

  localparam int PW = (NUM_LL > 1) ? $clog2(NUM_LL) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_TC   = CW'(STARVE_LIMIT);
  localparam logic [PW-1:0] LAST_CHAN   = PW'(NUM_LL - 1);

  wb_state_e                  state;
  wb_state_e                  state_d;
  logic [CW-1:0]              starve_cnt;
  logic [CW-1:0]              starve_cnt_d;

  logic [PW-1:0]              rr_ptr;
  logic [PW-1:0]              sel_idx;
  logic                       sel_found;
  logic [REG_ADDR_WIDTH-1:0]  sel_dest;
  logic [DATA_WIDTH-1:0]      sel_data;
  logic [NUM_LL-1:0]          sv_sh;
  int                         ch;
  logic                       grant;

  logic                       pw;
  logic [DATA_WIDTH-1:0]      pipe_data;

  wb_entry_t                  push_entry;
  wb_entry_t                  fifo_head;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;

  logic                       wr_en_d;
  logic [REG_ADDR_WIDTH-1:0]  wr_reg_d;
  logic [DATA_WIDTH-1:0]      wr_data_d;

  assign pw        = pipe_valid & pipe_reg_write & (pipe_reg_dest != '0);
  assign pipe_data = pipe_mem_to_reg ? pipe_mem_data : pipe_alu_data;

  // Round-robin search starting at rr_ptr; first asserted channel wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_dest  = '0;
    sel_data  = '0;
    sv_sh     = '0;
    ch        = 0;
    for (int k = 0; k < NUM_LL; k++) begin
      ch = int'(rr_ptr) + k;
      if (ch >= NUM_LL) ch = ch - NUM_LL;
      sv_sh = side_valid >> ch;
      if (!sel_found && sv_sh[0]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(ch);
        sel_dest  = REG_ADDR_WIDTH'(side_reg_dest >> (ch * REG_ADDR_WIDTH));
        sel_data  = DATA_WIDTH'(side_data >> (ch * DATA_WIDTH));
      end
    end
  end

  // A dest-0 result still consumes the grant but never enters the FIFO.
  assign grant      = sel_found & ~fifo_full & ~reset;
  assign side_ready = grant ? (NUM_LL'(1) << sel_idx) : '0;
  assign fifo_push  = grant & (sel_dest != '0);

  assign push_entry.reg_dest = sel_dest;
  assign push_entry.data     = sel_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (sel_idx == LAST_CHAN) ? '0 : sel_idx + 1'b1;
    end
  end

  cpu_wb_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .entry (push_entry),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (buf_count),
    .head  (fifo_head)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_d;
      starve_cnt <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    starve_cnt_d = starve_cnt;
    case (state)
      NORMAL: begin
        if (fifo_empty || fifo_pop) begin
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = starve_cnt + 1'b1;
          if (starve_cnt_d == STARVE_TC) state_d = DRAIN;
        end
      end
      DRAIN: begin
        starve_cnt_d = '0;
        state_d      = NORMAL;
      end
      default: begin
        starve_cnt_d = '0;
        state_d      = NORMAL;
      end
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    fifo_pop  = 1'b0;
    wr_en_d   = 1'b0;
    wr_reg_d  = '0;
    wr_data_d = '0;
    if (!reset) begin
      case (state)
        NORMAL: begin
          if (pw) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = pipe_reg_dest;
            wr_data_d = pipe_data;
          end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            wr_en_d   = 1'b1;
            wr_reg_d  = fifo_head.reg_dest;
            wr_data_d = fifo_head.data;
          end
        end
        DRAIN: begin
          stall = 1'b1;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            wr_en_d   = 1'b1;
            wr_reg_d  = fifo_head.reg_dest;
            wr_data_d = fifo_head.data;
          end
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= wr_en_d;
      rf_write_reg    <= wr_reg_d;
      rf_write_data   <= wr_data_d;
    end
  end

`ifdef CPU_WB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_side_writes  <= '0;
      perf_full_cycles  <= '0;
    end else begin
      if (state == DRAIN) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (fifo_pop)       perf_side_writes  <= perf_side_writes + 32'd1;
      if (fifo_full)      perf_full_cycles  <= perf_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_writeback_merge.sv
// Directed bench for cpu_writeback_merge: expected register writes are queued
// at issue time and a negedge monitor pops and compares each rf write.
module tb_cpu_writeback_merge;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int NLL = 2;
  localparam int BD  = 4;

  logic              clock;
  logic              reset;
  logic              pipe_valid;
  logic              pipe_reg_write;
  logic              pipe_mem_to_reg;
  logic [DW-1:0]     pipe_alu_data;
  logic [DW-1:0]     pipe_mem_data;
  logic [RW-1:0]     pipe_reg_dest;
  logic [NLL-1:0]    side_valid;
  logic [NLL-1:0]    side_ready;
  logic [NLL*RW-1:0] side_reg_dest;
  logic [NLL*DW-1:0] side_data;
  logic              rf_write_enable;
  logic [RW-1:0]     rf_write_reg;
  logic [DW-1:0]     rf_write_data;
  logic              stall;
  logic [2:0]        buf_count;
`ifdef CPU_WB_PERF_EN
  logic [31:0]       perf_stall_cycles;
  logic [31:0]       perf_side_writes;
  logic [31:0]       perf_full_cycles;
`endif

  typedef struct packed {
    logic [RW-1:0] r;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   p;
  int   e;

  cpu_writeback_merge #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (RW),
    .NUM_LL         (NLL),
    .BUF_DEPTH      (BD),
    .STARVE_LIMIT   (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pipe_valid      (pipe_valid),
    .pipe_reg_write  (pipe_reg_write),
    .pipe_mem_to_reg (pipe_mem_to_reg),
    .pipe_alu_data   (pipe_alu_data),
    .pipe_mem_data   (pipe_mem_data),
    .pipe_reg_dest   (pipe_reg_dest),
    .side_valid      (side_valid),
    .side_ready      (side_ready),
    .side_reg_dest   (side_reg_dest),
    .side_data       (side_data),
    .rf_write_enable (rf_write_enable),
    .rf_write_reg    (rf_write_reg),
    .rf_write_data   (rf_write_data),
    .stall           (stall),
    .buf_count       (buf_count)
`ifdef CPU_WB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_side_writes  (perf_side_writes),
    .perf_full_cycles  (perf_full_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [RW-1:0] r, input logic [DW-1:0] d);
    exp_t x;
    x.r = r;
    x.d = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    pipe_valid     = 1'b0;
    pipe_reg_write = 1'b0;
    side_valid     = '0;
  endtask

  task automatic set_pipe(input logic [RW-1:0] d, input logic [DW-1:0] a);
    pipe_valid      = 1'b1;
    pipe_reg_write  = 1'b1;
    pipe_mem_to_reg = 1'b0;
    pipe_reg_dest   = d;
    pipe_alu_data   = a;
    pipe_mem_data   = ~a;
  endtask

  task automatic set_side(input bit chn, input logic [RW-1:0] d, input logic [DW-1:0] v);
    if (chn) begin
      side_valid[1]       = 1'b1;
      side_reg_dest[9:5]  = d;
      side_data[63:32]    = v;
    end else begin
      side_valid[0]       = 1'b1;
      side_reg_dest[4:0]  = d;
      side_data[31:0]     = v;
    end
  endtask

  // Scoreboard monitor: every rf write must match the oldest expectation.
  always @(negedge clock) begin
    if (rf_write_enable === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got reg %0d data 0x%0h, expected no write at %0t",
                 rf_write_reg, rf_write_data, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("rf_write_reg", 32'(rf_write_reg), 32'(mon_e.r));
        chk("rf_write_data", rf_write_data, mon_e.d);
      end
    end
  end

  initial begin
    #50000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    reset           = 1'b1;
    pipe_valid      = 1'b0;
    pipe_reg_write  = 1'b0;
    pipe_mem_to_reg = 1'b0;
    pipe_alu_data   = '0;
    pipe_mem_data   = '0;
    pipe_reg_dest   = '0;
    side_valid      = 2'b11;
    side_reg_dest   = {5'd1, 5'd2};
    side_data       = {32'h11, 32'h22};

    // Reset values; side_ready must stay low while reset is high.
    cyc();
    cyc();
    #1;
    chk("reset_rf_we", 32'(rf_write_enable), 0);
    chk("reset_rf_reg", 32'(rf_write_reg), 0);
    chk("reset_rf_data", rf_write_data, 0);
    chk("reset_buf_count", 32'(buf_count), 0);
    chk("reset_stall", 32'(stall), 0);
    chk("reset_side_ready", 32'(side_ready), 0);
    reset = 1'b0;
    idle();
    cyc();

    // Pipe only: ALU then memory select, then non-writing slots.
    set_pipe(5'd5, 32'h1234);
    sb.push_back(mk(5'd5, 32'h1234));
    cyc();
    pipe_mem_to_reg = 1'b1;
    pipe_mem_data   = 32'hBEEF;
    pipe_alu_data   = 32'hDEAD;
    pipe_reg_dest   = 5'd6;
    sb.push_back(mk(5'd6, 32'hBEEF));
    cyc();
    pipe_reg_write = 1'b0;
    pipe_reg_dest  = 5'd7;
    cyc();
    pipe_valid     = 1'b0;
    pipe_reg_write = 1'b1;
    cyc();
    idle();
    cyc();
    cyc();
    chk("t1_sb_empty", 32'(sb.size()), 0);

    // Register 0 suppression for pipe and side.
    set_pipe(5'd0, 32'h55);
    cyc();
    idle();
    set_side(1'b1, 5'd0, 32'h77);
    #1;
    chk("t2_rf_we_dest0", 32'(rf_write_enable), 0);
    chk("t2_side_ready_dest0", 32'(side_ready), 2);
    cyc();
    idle();
    chk("t2_buf_count", 32'(buf_count), 0);
    cyc();
    cyc();
    chk("t2_sb_empty", 32'(sb.size()), 0);

    // Idle drain: both channels at once, ch0 first then ch1.
    set_side(1'b0, 5'd3, 32'hAA);
    set_side(1'b1, 5'd4, 32'hBB);
    sb.push_back(mk(5'd3, 32'hAA));
    sb.push_back(mk(5'd4, 32'hBB));
    #1;
    chk("t3_ready_first", 32'(side_ready), 1);
    cyc();
    side_valid[0] = 1'b0;
    #1;
    chk("t3_ready_second", 32'(side_ready), 2);
    chk("t3_buf_count_1", 32'(buf_count), 1);
    cyc();
    side_valid = '0;
    #1;
    chk("t3_buf_count_pushpop", 32'(buf_count), 1);
    cyc();
    chk("t3_buf_count_0", 32'(buf_count), 0);
    cyc();
    cyc();
    chk("t3_sb_empty", 32'(sb.size()), 0);

    // Round-robin pointer: after granting ch0, ch1 wins a tie.
    set_side(1'b0, 5'd8, 32'h10);
    sb.push_back(mk(5'd8, 32'h10));
    #1;
    chk("t3b_ready_ch0", 32'(side_ready), 1);
    cyc();
    set_side(1'b0, 5'd10, 32'h20);
    set_side(1'b1, 5'd11, 32'h21);
    sb.push_back(mk(5'd11, 32'h21));
    sb.push_back(mk(5'd10, 32'h20));
    #1;
    chk("t3b_ready_rr_ch1", 32'(side_ready), 2);
    cyc();
    side_valid[1] = 1'b0;
    #1;
    chk("t3b_ready_ch0_again", 32'(side_ready), 1);
    cyc();
    idle();
    cyc();
    cyc();
    cyc();
    chk("t3b_sb_empty", 32'(sb.size()), 0);

    // Full: pipe writes every cycle, five side pushes into a 4-deep FIFO.
    // Occupied from c1, forced drain lands in c9, 5th entry accepted in c10.
    p = 0;
    e = 0;
    for (int c = 0; c <= 10; c++) begin
      set_pipe(5'(20 + p), 32'h1000 + 32'(p));
      if (e < 5) set_side(1'b0, 5'(12 + e), 32'hE0 + 32'(e));
      else side_valid = '0;
      #1;
      chk("t4_stall", 32'(stall), (c == 9) ? 1 : 0);
      chk("t4_side_ready", 32'(side_ready), (c < 4 || c == 10) ? 1 : 0);
      if (c == 4) chk("t4_buf_count_full", 32'(buf_count), 4);
      if (c == 9) sb.push_back(mk(5'd12, 32'hE0));
      else begin
        sb.push_back(mk(5'(20 + p), 32'h1000 + 32'(p)));
        p++;
      end
      if (c < 4 || c == 10) e++;
      cyc();
    end
    idle();
    for (int i = 1; i < 5; i++) sb.push_back(mk(5'(12 + i), 32'hE0 + 32'(i)));
    for (int i = 0; i < 6; i++) cyc();
    chk("t4_buf_count_end", 32'(buf_count), 0);
    chk("t4_sb_empty", 32'(sb.size()), 0);

    // Starvation: one entry under continuous pipe writes, twice in a row so
    // the second drain also needs a counter restarted from zero.
    p = 0;
    for (int c = 0; c <= 20; c++) begin
      set_pipe(5'(1 + p), 32'h2000 + 32'(p));
      side_valid = '0;
      if (c == 0)  set_side(1'b1, 5'd30, 32'h5A5A);
      if (c == 10) set_side(1'b1, 5'd31, 32'hA5A5);
      #1;
      chk("t5_stall", 32'(stall), (c == 9 || c == 19) ? 1 : 0);
      chk("t5_side_ready", 32'(side_ready), (c == 0 || c == 10) ? 2 : 0);
      if (c == 10 || c == 20) chk("t5_buf_count_drained", 32'(buf_count), 0);
      if (c == 9) sb.push_back(mk(5'd30, 32'h5A5A));
      else if (c == 19) sb.push_back(mk(5'd31, 32'hA5A5));
      else begin
        sb.push_back(mk(5'(1 + p), 32'h2000 + 32'(p)));
        p++;
      end
      cyc();
    end
    idle();
    cyc();
    cyc();
    cyc();
    chk("t5_sb_empty", 32'(sb.size()), 0);

    // Reset with three buffered entries: they must never be written.
    for (int c = 0; c < 3; c++) begin
      set_pipe(5'(2 + c), 32'h3000 + 32'(c));
      set_side(1'b0, 5'(16 + c), 32'hC0 + 32'(c));
      sb.push_back(mk(5'(2 + c), 32'h3000 + 32'(c)));
      #1;
      chk("t6_side_ready", 32'(side_ready), 1);
      cyc();
    end
    chk("t6_buf_count_3", 32'(buf_count), 3);
    reset = 1'b1;
    set_pipe(5'd5, 32'h3003);
    set_side(1'b0, 5'd19, 32'hC3);
    #1;
    chk("t6_side_ready_in_reset", 32'(side_ready), 0);
    chk("t6_stall_in_reset", 32'(stall), 0);
    cyc();
    reset = 1'b0;
    idle();
    chk("t6_buf_count_after", 32'(buf_count), 0);
    chk("t6_rf_we_after", 32'(rf_write_enable), 0);
    chk("t6_stall_after", 32'(stall), 0);
    for (int i = 0; i < 6; i++) cyc();
    chk("t6_sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
